// File: rtl/cmp_bist_pkg.sv
// Shared types and constants for the comparator BIST sequencer.
package cmp_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Bit positions inside the {lt, eq, gt} result code
    localparam int unsigned GT_BIT = 0;
    localparam int unsigned EQ_BIT = 1;
    localparam int unsigned LT_BIT = 2;
    localparam int unsigned RES_W  = 3;

    localparam int unsigned WIDTH_DEFAULT = 2;
    localparam int unsigned NUM_PAIRS     = 2 ** (2 * WIDTH_DEFAULT);

endpackage

// File: rtl/cmp_golden.sv
// Combinational reference comparator: one-hot {lt, eq, gt} for unsigned operands.
module cmp_golden
    import cmp_bist_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [RES_W-1:0] exp_code_c_o
);

    always_comb begin
        exp_code_c_o         = '0;
        exp_code_c_o[GT_BIT] = (a_i > b_i);
        exp_code_c_o[EQ_BIT] = (a_i == b_i);
        exp_code_c_o[LT_BIT] = (a_i < b_i);
    end

endmodule

// File: rtl/cmp_bist_sequencer.sv
// Sweeps every (A,B) pair through an external comparator, checks its flags
// against cmp_golden after a settle time, and reports pass/fail details.
module cmp_bist_sequencer
    import cmp_bist_pkg::*;
#(
    parameter int unsigned WIDTH         = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned ERR_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             gt_in,
    input  logic             eq_in,
    input  logic             lt_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int unsigned      CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] OP_MAX   = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
    logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               fail_valid_q, fail_valid_d;
    logic [WIDTH-1:0]   fail_a_q, fail_a_d, fail_b_q, fail_b_d;

    logic [RES_W-1:0]   exp_code_c;
    logic [RES_W-1:0]   flags_c;
    logic               mismatch_c;
    logic [ERR_W-1:0]   err_upd_c;

    cmp_golden #(.WIDTH(WIDTH)) u_golden (
        .a_i          (cmp_a_q),
        .b_i          (cmp_b_q),
        .exp_code_c_o (exp_code_c)
    );

    always_comb begin
        flags_c         = '0;
        flags_c[GT_BIT] = gt_in;
        flags_c[EQ_BIT] = eq_in;
        flags_c[LT_BIT] = lt_in;
    end

    // Any differing bit counts, so non-one-hot flag codes are caught too
    assign mismatch_c = (flags_c != exp_code_c);
    assign err_upd_c  = (!mismatch_c || err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmp_a_d      = cmp_a_q;
        cmp_b_d      = cmp_b_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cmp_a_d      = '0;
                    cmp_b_d      = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_a_d     = '0;
                    fail_b_d     = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                    cnt_d        = CNT_LOAD;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SAMPLE: begin
                err_d = err_upd_c;
                if (mismatch_c && !fail_valid_q) begin
                    fail_valid_d = 1'b1;
                    fail_a_d     = cmp_a_q;
                    fail_b_d     = cmp_b_q;
                end
                // Last pair ends the sweep with the operands left in place
                if (cmp_a_q == OP_MAX && cmp_b_q == OP_MAX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_upd_c == '0);
                    state_d = DONE;
                end else begin
                    cmp_b_d = cmp_b_q + WIDTH'(1);
                    if (cmp_b_q == OP_MAX) begin
                        cmp_a_d = cmp_a_q + WIDTH'(1);
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cmp_a_q      <= '0;
            cmp_b_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmp_a_q      <= cmp_a_d;
            cmp_b_q      <= cmp_b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
        end
    end

    assign cmp_a      = cmp_a_q;
    assign cmp_b      = cmp_b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;

endmodule
